// File: rtl/cursor_draw.sv
// cursor_draw
// Overlays a crosshair cursor on a pixel stream coming down the draw chain.
// The cursor position and visibility are sampled once per frame, on the
// rising edge of vertical blanking, so the crosshair never tears mid-frame.
// Timing and pixel data pass through a two-stage pipeline (S1 computes the
// crosshair hit, S2 composites the colour).
//
// Ports
//   clk                     pixel clock, rising-edge active
//   rst                     asynchronous active-high reset
//   hcount_in, vcount_in    pixel column / row (11 bits)
//   hsync_in, vsync_in      sync flags aligned with the counts
//   hblnk_in, vblnk_in      blanking flags aligned with the counts
//   rgb_in                  background colour (12 bits)
//   xpos, ypos              mouse position (12 bits each)
//   cursor_en               crosshair visibility request
//   *_out                   the same timing signals delayed by 2 clocks,
//                           rgb_out carries the composited pixel
module cursor_draw #(
  parameter int          ARM   = 8,
  parameter int          GAP   = 2,
  parameter logic [11:0] COLOR = 12'hF00,
  parameter int          XMAX  = 799,
  parameter int          YMAX  = 599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        cursor_en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] XMAX_W = 12'(XMAX);
  localparam logic [11:0] YMAX_W = 12'(YMAX);
  localparam logic [11:0] XMID_W = 12'(XMAX / 2);
  localparam logic [11:0] YMID_W = 12'(YMAX / 2);
  localparam logic [11:0] ARM_W  = 12'(ARM);
  localparam logic [11:0] GAP_W  = 12'(GAP);

  // frame-rate cursor state
  logic        vblnk_d_r;
  logic [11:0] pos_x_r;
  logic [11:0] pos_y_r;
  logic        en_q_r;

  // combinational S1 inputs
  logic        vedge_s;
  logic [11:0] xclamp_s;
  logic [11:0] yclamp_s;
  logic [11:0] hpix_s;
  logic [11:0] vpix_s;
  logic [11:0] dx_s;
  logic [11:0] dy_s;
  logic        hit_s;

  // stage S1 registers
  logic [10:0] hcount_s1_r;
  logic [10:0] vcount_s1_r;
  logic        hsync_s1_r;
  logic        vsync_s1_r;
  logic        hblnk_s1_r;
  logic        vblnk_s1_r;
  logic [11:0] rgb_s1_r;
  logic        hit_s1_r;

  // Vblank rising edge, position clamp and unsigned distances to the centre.
  always_comb begin
    vedge_s = vblnk_in & ~vblnk_d_r;

    // full 12-bit compare so out-of-range mouse values pin to the edge
    if (xpos > XMAX_W) begin
      xclamp_s = XMAX_W;
    end else begin
      xclamp_s = xpos;
    end
    if (ypos > YMAX_W) begin
      yclamp_s = YMAX_W;
    end else begin
      yclamp_s = ypos;
    end

    hpix_s = {1'b0, hcount_in};
    vpix_s = {1'b0, vcount_in};

    // absolute difference without wrap: arms are clipped, never folded over
    if (hpix_s >= pos_x_r) begin
      dx_s = hpix_s - pos_x_r;
    end else begin
      dx_s = pos_x_r - hpix_s;
    end
    if (vpix_s >= pos_y_r) begin
      dy_s = vpix_s - pos_y_r;
    end else begin
      dy_s = pos_y_r - vpix_s;
    end

    hit_s = 1'b0;
    if (!en_q_r) begin
      hit_s = 1'b0;
    end else if ((dx_s == 12'd0) && (dy_s >= GAP_W) && (dy_s <= ARM_W)) begin
      hit_s = 1'b1;
    end else if ((dy_s == 12'd0) && (dx_s >= GAP_W) && (dx_s <= ARM_W)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Latch cursor position and visibility once per frame at the vblank edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_d_r <= 1'b0;
      pos_x_r   <= XMID_W;
      pos_y_r   <= YMID_W;
      en_q_r    <= 1'b0;
    end else begin
      vblnk_d_r <= vblnk_in;
      if (vedge_s) begin
        pos_x_r <= xclamp_s;
        pos_y_r <= yclamp_s;
        en_q_r  <= cursor_en;
      end else begin
        pos_x_r <= pos_x_r;
        pos_y_r <= pos_y_r;
        en_q_r  <= en_q_r;
      end
    end
  end

  // Stage S1: register timing, background colour and the crosshair hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_s1_r <= 11'd0;
      vcount_s1_r <= 11'd0;
      hsync_s1_r  <= 1'b0;
      vsync_s1_r  <= 1'b0;
      hblnk_s1_r  <= 1'b0;
      vblnk_s1_r  <= 1'b0;
      rgb_s1_r    <= 12'h000;
      hit_s1_r    <= 1'b0;
    end else begin
      hcount_s1_r <= hcount_in;
      vcount_s1_r <= vcount_in;
      hsync_s1_r  <= hsync_in;
      vsync_s1_r  <= vsync_in;
      hblnk_s1_r  <= hblnk_in;
      vblnk_s1_r  <= vblnk_in;
      rgb_s1_r    <= rgb_in;
      hit_s1_r    <= hit_s;
    end
  end

  // Stage S2: composite the pixel; blanking always forces black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= hcount_s1_r;
      vcount_out <= vcount_s1_r;
      hsync_out  <= hsync_s1_r;
      vsync_out  <= vsync_s1_r;
      hblnk_out  <= hblnk_s1_r;
      vblnk_out  <= vblnk_s1_r;
      if (hblnk_s1_r | vblnk_s1_r) begin
        rgb_out <= 12'h000;
      end else if (hit_s1_r) begin
        rgb_out <= COLOR;
      end else begin
        rgb_out <= rgb_s1_r;
      end
    end
  end

endmodule

// File: tb/tb_cursor_draw.sv
// tb_cursor_draw
// Directed bench for cursor_draw with default parameters (ARM 8, GAP 2,
// colour 12'hF00, 800x600 visible). Each driven pixel's expected output is
// queued and compared against the DUT output two clocks later. The expected
// crosshair is written out as explicit arm ranges around a centre that the
// bench sets by hand whenever it issues a vblank edge.
module tb_cursor_draw;

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        cursor_en;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int hit_cnt    = 0;

  // bench copy of the latched cursor state (set by hand at each vblank edge)
  int cx = 399;
  int cy = 299;
  bit ex = 1'b0;

  logic [37:0] exp_q[$];

  cursor_draw dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .cursor_en  (cursor_en),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  // Pixel clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] out_vec();
    return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
  endfunction

  function automatic logic [11:0] bg_of(input int h, input int v);
    logic [10:0] hh;
    logic [10:0] vv;
    hh = h[10:0];
    vv = v[10:0];
    // top nibble 0 so background can never look like the cursor colour
    return {4'h0, hh[3:0], vv[3:0]};
  endfunction

  function automatic logic [11:0] exp_rgb(input int h, input int v, input logic hb,
                                          input logic vb, input logic [11:0] bg);
    bit in_h;
    bit in_v;
    in_h = ((h >= cx - 8) && (h <= cx - 2)) || ((h >= cx + 2) && (h <= cx + 8));
    in_v = ((v >= cy - 8) && (v <= cy - 2)) || ((v >= cy + 2) && (v <= cy + 8));
    if (hb || vb) return 12'h000;
    if (ex && (((v == cy) && in_h) || ((h == cx) && in_v))) return 12'hF00;
    return bg;
  endfunction

  // Drive one pixel, clock it, and compare the pixel driven one step earlier.
  task automatic step(input int h, input int v, input logic hb, input logic vb,
                      input logic [11:0] bg);
    logic [10:0] hh;
    logic [10:0] vv;
    logic hs;
    logic vs;
    hh = h[10:0];
    vv = v[10:0];
    hs = hh[1] ^ vv[0];
    vs = vv[2];
    hcount_in = hh;
    vcount_in = vv;
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = bg;
    exp_q.push_back({hh, vv, hs, vs, hb, vb, exp_rgb(h, v, hb, vb, bg)});
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      check_val($sformatf("pix h=%0d v=%0d", hcount_out, vcount_out), {26'd0, out_vec()},
                {26'd0, exp_q[0]});
      if (rgb_out == 12'hF00) hit_cnt++;
      void'(exp_q.pop_front());
    end
  endtask

  // Scan a window with a background pattern, then one flush pixel.
  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    hit_cnt = 0;
    for (int v = y0; v <= y1; v++) begin
      for (int h = x0; h <= x1; h++) begin
        step(h, v, logic'(h > 799), logic'(v > 599), bg_of(h, v));
      end
    end
    step(0, 0, 1'b1, 1'b0, 12'h000);
  endtask

  // Issue a vblank rising edge with the given mouse inputs; ecx/ecy are the
  // hand-computed clamped centre the bench expects afterwards.
  task automatic vblank_edge(input int xp, input int yp, input bit en, input int ecx,
                             input int ecy);
    xpos      = xp[11:0];
    ypos      = yp[11:0];
    cursor_en = en;
    step(0, 0, 1'b1, 1'b0, 12'h000);
    step(0, 600, 1'b1, 1'b1, 12'h000);
    cx = ecx;
    cy = ecy;
    ex = en;
    step(0, 601, 1'b1, 1'b0, 12'h000);
  endtask

  initial begin
    rst       = 1'b1;
    hcount_in = 11'd0;
    vcount_in = 11'd0;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    hblnk_in  = 1'b0;
    vblnk_in  = 1'b0;
    rgb_in    = 12'h000;
    xpos      = 12'd0;
    ypos      = 12'd0;
    cursor_en = 1'b0;

    // reset state, with busy inputs to show they are ignored
    hcount_in = 11'd123;
    rgb_in    = 12'hABC;
    hblnk_in  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {26'd0, out_vec()}, 64'd0);
    rst = 1'b0;

    // constant background, cursor disabled: straight 2-cycle delay,
    // and no crosshair before the first vblank edge even at the reset centre
    cursor_en = 1'b1;
    for (int h = 395; h <= 405; h++) step(h, 299, 1'b0, 1'b0, 12'h0AA);
    step(399, 291, 1'b0, 1'b0, 12'h0AA);
    step(0, 0, 1'b1, 1'b0, 12'h000);

    // centred crosshair: 28 pixels, gap around the centre
    vblank_edge(400, 300, 1'b1, 400, 300);
    scan(391, 409, 291, 309);
    check_val("centre_hits", 64'(hit_cnt), 64'd28);

    // clamp to bottom-right corner: only left and up arms visible
    vblank_edge(2000, 4095, 1'b1, 799, 599);
    scan(785, 810, 585, 610);
    check_val("corner_hits", 64'(hit_cnt), 64'd14);

    // mid-frame position change is ignored until the next vblank edge
    vblank_edge(100, 50, 1'b1, 100, 50);
    scan(90, 110, 50, 50);
    check_val("frame1_x100_row", 64'(hit_cnt), 64'd14);
    xpos = 12'd500;
    scan(90, 110, 50, 50);
    check_val("midframe_x100_row", 64'(hit_cnt), 64'd14);
    scan(490, 510, 50, 50);
    check_val("midframe_x500_row", 64'(hit_cnt), 64'd0);
    vblank_edge(500, 50, 1'b1, 500, 50);
    scan(490, 510, 50, 50);
    check_val("frame2_x500_row", 64'(hit_cnt), 64'd14);
    scan(500, 500, 40, 60);
    check_val("frame2_x500_col", 64'(hit_cnt), 64'd14);
    scan(90, 110, 50, 50);
    check_val("frame2_x100_row", 64'(hit_cnt), 64'd0);

    // asynchronous reset mid-frame while the crosshair is being drawn
    for (int h = 495; h <= 499; h++) step(h, 50, 1'b0, 1'b0, bg_of(h, 50));
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_outputs", {26'd0, out_vec()}, 64'd0);
    @(posedge clk);
    #1;
    check_val("rst_held_outputs", {26'd0, out_vec()}, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    cx = 399;
    cy = 299;
    ex = 1'b0;

    // cursor requested but not yet latched: nothing drawn
    xpos      = 12'd300;
    ypos      = 12'd200;
    cursor_en = 1'b1;
    scan(290, 310, 200, 200);
    check_val("post_rst_no_cursor", 64'(hit_cnt), 64'd0);
    scan(399, 399, 290, 308);
    check_val("post_rst_no_centre", 64'(hit_cnt), 64'd0);

    // after the next vblank edge the new position is drawn
    vblank_edge(300, 200, 1'b1, 300, 200);
    scan(290, 310, 200, 200);
    check_val("post_rst_row", 64'(hit_cnt), 64'd14);
    scan(300, 300, 190, 210);
    check_val("post_rst_col", 64'(hit_cnt), 64'd14);

    // cursor_en=0 latched at a vblank edge hides the crosshair
    vblank_edge(300, 200, 1'b0, 300, 200);
    scan(290, 310, 200, 200);
    check_val("disabled_row", 64'(hit_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
